valid_ready_multi_port_out_of_order_buffer: RTL

Out-of-order buffer with one allocating write port and `READ_PORTS` independent indexed read ports, each with a registered, back-pressurable response channel. A write stores data in the lowest free slot and returns that slot index. Each read port fetches by index and can optionally free the slot. It sits between producers that hand out tags and consumers that retire tagged entries in any order, including from several consumers in parallel.

---
 rtl/valid_ready_multi_port_out_of_order_buffer_if.sv | 42 ++++
 rtl/valid_ready_multi_port_out_of_order_buffer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/valid_ready_multi_port_out_of_order_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : valid_ready_multi_port_out_of_order_buffer_if
// Brief   : Handshake bundle for the out-of-order buffer (write, read, response)
// Revision: 1.0 - initial release
// ============================================================================
interface valid_ready_multi_port_out_of_order_buffer_if #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int READ_PORTS  = 2,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
);
    logic                              full;
    logic                              empty;
    logic [COUNT_WIDTH-1:0]            count;
    logic                              write_valid;
    logic [WIDTH-1:0]                  write_data;
    logic [INDEX_WIDTH-1:0]            write_index;
    logic                              write_ready;
    logic [READ_PORTS-1:0]             read_valid;
    logic [READ_PORTS-1:0]             read_clear;
    logic [READ_PORTS*INDEX_WIDTH-1:0] read_index;
    logic [READ_PORTS-1:0]             read_ready;
    logic [READ_PORTS-1:0]             response_valid;
    logic [READ_PORTS*WIDTH-1:0]       response_data;
    logic [READ_PORTS-1:0]             response_error;
    logic [READ_PORTS-1:0]             response_ready;

    modport slave (
        input  write_valid, write_data, read_valid, read_clear, read_index, response_ready,
        output full, empty, count, write_index, write_ready, read_ready,
               response_valid, response_data, response_error
    );

    modport master (
        output write_valid, write_data, read_valid, read_clear, read_index, response_ready,
        input  full, empty, count, write_index, write_ready, read_ready,
               response_valid, response_data, response_error
    );
endinterface
`default_nettype wire

// File: rtl/valid_ready_multi_port_out_of_order_buffer.sv
`default_nettype none
// ============================================================================
// Module  : valid_ready_multi_port_out_of_order_buffer
// Brief   : Tag-allocating buffer, one write port, N indexed read/free ports
// Revision: 1.0 - initial release
// ============================================================================
module valid_ready_multi_port_out_of_order_buffer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int READ_PORTS  = 2,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input wire logic clock,
    input wire logic reset,
    valid_ready_multi_port_out_of_order_buffer_if.slave bus
);
    localparam logic [INDEX_WIDTH:0]   c_depth_ext   = (INDEX_WIDTH + 1)'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] c_depth_count = COUNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]            r_data [DEPTH];
    logic [DEPTH-1:0]            r_occupied;
    logic [COUNT_WIDTH-1:0]      r_count;
    logic [READ_PORTS-1:0]       r_resp_valid;
    logic [READ_PORTS-1:0]       r_resp_error;
    logic [READ_PORTS*WIDTH-1:0] r_resp_data;

    logic                        w_full;
    logic                        w_write_accept;
    logic [INDEX_WIDTH-1:0]      w_write_index;
    logic [DEPTH-1:0]            w_write_onehot;
    logic [DEPTH-1:0]            w_clear_mask;
    logic [COUNT_WIDTH-1:0]      w_freed;
    logic [READ_PORTS-1:0]       w_read_ready;
    logic [READ_PORTS-1:0]       w_accept;
    logic [READ_PORTS-1:0]       w_hit;
    logic [INDEX_WIDTH-1:0]      w_idx    [READ_PORTS];
    logic [WIDTH-1:0]            w_lookup [READ_PORTS];

    assign w_full         = (r_count == c_depth_count);
    assign w_write_accept = bus.write_valid & ~w_full;

    // Lowest free slot; stays 0 when nothing is free.
    always_comb begin
        logic w_found;
        w_write_index = '0;
        w_found       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found && !r_occupied[i]) begin
                w_write_index = INDEX_WIDTH'(i);
                w_found       = 1'b1;
            end
        end
    end

    always_comb begin
        w_write_onehot = '0;
        if (w_write_accept) begin
            w_write_onehot[w_write_index] = 1'b1;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        assign w_idx[p]        = bus.read_index[p*INDEX_WIDTH +: INDEX_WIDTH];
        assign w_read_ready[p] = ~r_resp_valid[p] | bus.response_ready[p];
        assign w_accept[p]     = bus.read_valid[p] & w_read_ready[p];
        assign w_hit[p]        = ({1'b0, w_idx[p]} < c_depth_ext) && r_occupied[w_idx[p]];
        assign w_lookup[p]     = w_hit[p] ? r_data[w_idx[p]] : '0;
    end

    // Ports hitting the same slot merge into one clear, so it is freed once.
    always_comb begin
        w_clear_mask = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (w_accept[p] && w_hit[p] && bus.read_clear[p]) begin
                w_clear_mask[w_idx[p]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_freed = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_freed = w_freed + COUNT_WIDTH'(w_clear_mask[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_occupied   <= '0;
            r_count      <= '0;
            r_resp_valid <= '0;
            r_resp_error <= '0;
            r_resp_data  <= '0;
        end else begin
            // The write slot was free at cycle start, so it never overlaps a clear.
            r_occupied <= (r_occupied & ~w_clear_mask) | w_write_onehot;
            r_count    <= r_count + COUNT_WIDTH'(w_write_accept) - w_freed;
            for (int p = 0; p < READ_PORTS; p++) begin
                if (w_accept[p]) begin
                    r_resp_valid[p]               <= 1'b1;
                    r_resp_data[p*WIDTH +: WIDTH] <= w_lookup[p];
                    r_resp_error[p]               <= ~w_hit[p];
                end else if (bus.response_ready[p]) begin
                    r_resp_valid[p] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_write_accept) begin
            r_data[w_write_index] <= bus.write_data;
        end
    end

    assign bus.full           = w_full;
    assign bus.empty          = (r_count == '0);
    assign bus.count          = r_count;
    assign bus.write_index    = w_write_index;
    assign bus.write_ready    = ~w_full;
    assign bus.read_ready     = w_read_ready;
    assign bus.response_valid = r_resp_valid;
    assign bus.response_data  = r_resp_data;
    assign bus.response_error = r_resp_error;
endmodule
`default_nettype wire
